// File: rtl/gray_updown_counter_system.sv
// Push-button Gray counter: synchronise and debounce the button, turn each accepted press
// into one up/down step of a binary counter, and mirror it as Gray code on the LEDs.
module gray_updown_counter_system #(
  parameter int unsigned N          = 8,
  parameter int unsigned DEB_CYCLES = 4,
  parameter bit          WRAP       = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         noisy,
  input  logic         dir,
  input  logic         clr,
  output logic [N-1:0] leds,
  output logic [N-1:0] bin,
  output logic         step,
  output logic         at_limit
);

  localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DLAST = DCW'(DEB_CYCLES - 1);

  // Two-flop synchronisers, bit 0 = noisy, 1 = dir, 2 = clr
  logic [2:0] s1_d, s1_q, s2_d, s2_q;
  logic       noisy_s2, dir_s2, clr_s2;

  logic [DCW-1:0] dcnt_d, dcnt_q;
  logic           db_d, db_q;
  logic           db_dly_d, db_dly_q;
  logic [N-1:0]   bin_d, bin_q;
  logic [N-1:0]   leds_d, leds_q;

  assign noisy_s2 = s2_q[0];
  assign dir_s2   = s2_q[1];
  assign clr_s2   = s2_q[2];

  always_comb begin
    s1_d = {clr, dir, noisy};
    s2_d = s1_q;
  end

  // Debouncer: a new level must persist DEB_CYCLES consecutive synchronised cycles
  always_comb begin
    dcnt_d   = '0;
    db_d     = db_q;
    db_dly_d = db_q;
    if (noisy_s2 != db_q) begin
      if (dcnt_q == DLAST) begin
        db_d = ~db_q;
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end
    end
  end

  assign step = db_q & ~db_dly_q;

  // Clear beats step; saturating mode holds at the limit in the current direction
  always_comb begin
    bin_d = bin_q;
    if (clr_s2) begin
      bin_d = '0;
    end else if (step) begin
      if (dir_s2) begin
        if (WRAP || (bin_q != '1)) bin_d = bin_q + N'(1);
      end else begin
        if (WRAP || (bin_q != '0)) bin_d = bin_q - N'(1);
      end
    end
    leds_d = bin_d ^ (bin_d >> 1);
  end

  assign at_limit = !WRAP && (dir_s2 ? (bin_q == '1) : (bin_q == '0));
  assign bin      = bin_q;
  assign leds     = leds_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      dcnt_q   <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      bin_q    <= '0;
      leds_q   <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      dcnt_q   <= dcnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      bin_q    <= bin_d;
      leds_q   <= leds_d;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter_system.sv
// Directed bench: one wrapping and one saturating instance share the same stimulus.
module tb_gray_updown_counter_system;

  logic       clk = 1'b0;
  logic       reset, noisy, dir, clr;
  logic [7:0] leds_w, bin_w, leds_s, bin_s;
  logic       step_w, step_s, lim_w, lim_s;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  gray_updown_counter_system #(.N(8), .DEB_CYCLES(4), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .noisy(noisy), .dir(dir), .clr(clr),
    .leds(leds_w), .bin(bin_w), .step(step_w), .at_limit(lim_w));

  gray_updown_counter_system #(.N(8), .DEB_CYCLES(4), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .noisy(noisy), .dir(dir), .clr(clr),
    .leds(leds_s), .bin(bin_s), .step(step_s), .at_limit(lim_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold the button for 'hold' cycles then release; count steps seen on each instance
  task automatic press(input int hold, output int nw, output int ns);
    nw = 0;
    ns = 0;
    noisy = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (step_w) nw++;
      if (step_s) ns++;
    end
    noisy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (step_w) nw++;
      if (step_s) ns++;
    end
  endtask

  initial begin
    int nw, ns;
    logic [7:0] exp_leds [4];
    exp_leds[0] = 8'h03; exp_leds[1] = 8'h02; exp_leds[2] = 8'h06; exp_leds[3] = 8'h07;

    reset = 1'b0; noisy = 1'b0; dir = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_leds", 32'(leds_w), 32'h0);
    check("rst_bin", 32'(bin_w), 32'h0);
    check("rst_step", 32'(step_w), 32'h0);
    check("rst_lim_wrap", 32'(lim_w), 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("lim_sat_up_at0", 32'(lim_s), 32'h0);

    // Latency of a clean press: step after E5, leds change at E6
    noisy = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) check("lat_nostep_E4", 32'(step_w), 32'h0);
      if (k == 6) begin
        check("lat_step_E5", 32'(step_w), 32'h1);
        check("lat_leds_E5", 32'(leds_w), 32'h0);
      end
      if (k == 7) begin
        check("lat_step_E6", 32'(step_w), 32'h0);
        check("lat_leds_E6", 32'(leds_w), 32'h01);
      end
    end
    repeat (3) @(negedge clk);
    noisy = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      press(10, nw, ns);
      check("up_steps", 32'(nw), 32'h1);
      check("up_leds", 32'(leds_w), 32'(exp_leds[i]));
      check("up_bin", 32'(bin_w), 32'(i + 2));
      check("up_bin_sat", 32'(bin_s), 32'(i + 2));
    end

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    check("arst_bin", 32'(bin_w), 32'h0);
    check("arst_leds", 32'(leds_w), 32'h0);
    check("arst_bin_sat", 32'(bin_s), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Bounce and short pulse rejection
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      noisy = ~noisy;
      repeat (2) begin
        @(negedge clk);
        if (step_w) nw++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (step_w) nw++;
    end
    noisy = 1'b1;
    repeat (3) @(negedge clk);
    noisy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (step_w) nw++;
    end
    check("bounce_steps", 32'(nw), 32'h0);
    check("bounce_leds", 32'(leds_w), 32'h0);

    press(10, nw, ns);
    check("resume_bin", 32'(bin_w), 32'h1);

    // Down to zero, then down-wrap vs saturate
    dir = 1'b0;
    press(10, nw, ns);
    check("down_bin", 32'(bin_w), 32'h0);
    check("down_bin_sat", 32'(bin_s), 32'h0);
    check("lim_sat_down_at0", 32'(lim_s), 32'h1);
    check("lim_wrap_down_at0", 32'(lim_w), 32'h0);
    press(10, nw, ns);
    check("wrapdn_bin", 32'(bin_w), 32'hFF);
    check("wrapdn_leds", 32'(leds_w), 32'h80);
    check("satdn_bin", 32'(bin_s), 32'h0);
    check("satdn_leds", 32'(leds_s), 32'h0);
    check("satdn_step", 32'(ns), 32'h1);
    dir = 1'b1;
    repeat (4) @(negedge clk);
    check("lim_sat_up_at0b", 32'(lim_s), 32'h0);
    press(10, nw, ns);
    check("wrapup_bin", 32'(bin_w), 32'h0);
    check("wrapup_leds", 32'(leds_w), 32'h0);
    check("sat_bin1", 32'(bin_s), 32'h1);

    // Climb to the top of the saturating instance
    for (int i = 0; i < 254; i++) press(8, nw, ns);
    check("climb_bin_sat", 32'(bin_s), 32'hFF);
    check("climb_bin_wrap", 32'(bin_w), 32'hFE);
    check("lim_sat_up_atFF", 32'(lim_s), 32'h1);
    check("lim_wrap_upFE", 32'(lim_w), 32'h0);
    press(8, nw, ns);
    check("satup_bin", 32'(bin_s), 32'hFF);
    check("satup_leds", 32'(leds_s), 32'h80);
    check("satup_step", 32'(ns), 32'h1);
    check("wrap_bin_FF", 32'(bin_w), 32'hFF);
    press(8, nw, ns);
    check("wrap_up_bin0", 32'(bin_w), 32'h0);
    check("wrap_up_leds0", 32'(leds_w), 32'h0);
    check("satup2_bin", 32'(bin_s), 32'hFF);

    // Clear overrides a simultaneous step
    clr = 1'b1;
    repeat (4) @(negedge clk);
    press(10, nw, ns);
    check("clr_step", 32'(nw), 32'h1);
    check("clr_bin_wrap", 32'(bin_w), 32'h0);
    check("clr_bin_sat", 32'(bin_s), 32'h0);
    check("clr_leds_sat", 32'(leds_s), 32'h0);
    clr = 1'b0;
    repeat (4) @(negedge clk);

    // Long hold yields a single step
    press(50, nw, ns);
    check("hold_steps", 32'(nw), 32'h1);
    check("hold_bin", 32'(bin_w), 32'h1);
    check("hold_leds", 32'(leds_w), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
